fifo_wptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the asynchronous FIFO. Tracks the binary write pointer and drives the memory write address and write enable. Publishes a registered Gray-coded write pointer for synchronisation into the read domain. Takes the read domain's Gray pointer, synchronises it through two flops, and compares it against the next write pointer to produce a registered full flag, with an optional almost-full flag.

---
 rtl/fifo_wptr_full.sv | 112 +++++++++++
 tb/tb_fifo_wptr_full.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain side of the asynchronous FIFO.
// Keeps the binary write pointer and drives the memory write strobe and
// address. Publishes a registered Gray write pointer, synchronises the read
// domain's Gray pointer through two flops and derives a registered full flag.
// Optional almost-full flag: define FIFO_ALMOST_FULL_EN to build it; when the
// macro is undefined, walmost_full is tied low.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic                  woverflow
);

  localparam int P = ADDR_WIDTH + 1;

  // Registered state
  logic [P-1:0] wbin_q,  wbin_d;
  logic [P-1:0] wgray_q, wgray_d;
  logic [P-1:0] rq1_q,   rq1_d;
  logic [P-1:0] rq2_q,   rq2_d;
  logic         wfull_q, wfull_d;
  logic         woverflow_q, woverflow_d;

  // Combinational helpers
  logic         wpush;
  logic [P-1:0] full_pat;

  // Accept a write only when not full; pointer advances modulo 2^P
  always_comb begin
    wpush   = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, wpush};
    wgray_d = wbin_d ^ (wbin_d >> 1);
  end

  // Full when the next write pointer equals the synchronised read pointer
  // with its two MSBs inverted (one full lap ahead, in Gray terms)
  always_comb begin
    full_pat    = {~rq2_q[P-1:P-2], rq2_q[P-3:0]};
    wfull_d     = (wgray_d == full_pat);
    woverflow_d = winc & wfull_q;
    rq1_d       = rptr_gray;
    rq2_d       = rq1_q;
  end

  // Pointer, synchroniser and flag registers with synchronous reset
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      rq1_q       <= '0;
      rq2_q       <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      rq1_q       <= rq1_d;
      rq2_q       <= rq2_d;
      wfull_q     <= wfull_d;
      woverflow_q <= woverflow_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [P-1:0] AFULL_P = P'(AFULL_THRESH);

  logic [P-1:0] rbin;
  logic [P-1:0] level;
  logic         walmost_full_q, walmost_full_d;

  // Gray-to-binary of the synchronised read pointer: MSB passes through,
  // each lower bit is the XOR of the bit above (binary) and its Gray bit
  always_comb begin
    rbin[P-1] = rq2_q[P-1];
    for (int unsigned i = 1; i < P; i++) begin
      rbin[P-1-i] = rbin[P-i] ^ rq2_q[P-1-i];
    end
  end

  // Fill level after this cycle's write, compared against the threshold
  always_comb begin
    level          = wbin_d - rbin;
    walmost_full_d = (level >= AFULL_P);
  end

  // Almost-full register with synchronous reset
  always_ff @(posedge wclk) begin
    if (wrst) walmost_full_q <= 1'b0;
    else      walmost_full_q <= walmost_full_d;
  end

  assign walmost_full = walmost_full_q;
`else
  assign walmost_full = 1'b0;
`endif

  assign wen       = wpush;
  assign waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray = wgray_q;
  assign wfull     = wfull_q;
  assign woverflow = woverflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Testbench for fifo_wptr_full (ADDR_WIDTH=4, AFULL_THRESH=12).
// Reference model tracks write/read counts as plain integers; the full and
// almost-full flags come from their difference against the read count seen
// two edges earlier.
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [4:0] rptr_gray;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic       woverflow;

  fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .wen          (wen),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  int tests = 0;
  int fails = 0;

  // Model state: accepted writes, driven read count, read count as seen
  // one and two edges later, and expected registered flags
  int wcnt = 0;
  int rcnt = 0;
  int s1 = 0;
  int s2 = 0;
  bit mfull = 1'b0;
  bit movf  = 1'b0;
  bit mafull = 1'b0;
  int wraps = 0;
  logic [3:0] prev_addr = 4'd0;

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit w, input bit r);
    bit acc;
    int lvl;
    winc      = w;
    wrst      = r;
    rptr_gray = to_gray(rcnt);
    @(negedge wclk);
    check("wen", {31'd0, wen}, {31'd0, w & ~mfull});
    check("waddr", {28'd0, waddr}, 32'(wcnt % 16));
    @(posedge wclk);
    if (r) begin
      wcnt = 0; s1 = 0; s2 = 0;
      mfull = 0; movf = 0; mafull = 0;
    end else begin
      acc  = w && !mfull;
      movf = w && mfull;
      if (acc) wcnt++;
      lvl   = (wcnt - s2) % 32;
      mfull = (lvl == 16);
`ifdef FIFO_ALMOST_FULL_EN
      mafull = (lvl >= 12);
`else
      mafull = 1'b0;
`endif
      s2 = s1;
      s1 = rcnt;
    end
    #1;
    check("wptr_gray", {27'd0, wptr_gray}, {27'd0, to_gray(wcnt)});
    check("wfull", {31'd0, wfull}, {31'd0, mfull});
    check("woverflow", {31'd0, woverflow}, {31'd0, movf});
    check("walmost_full", {31'd0, walmost_full}, {31'd0, mafull});
  endtask

  initial begin
    winc = 1'b0; wrst = 1'b1; rptr_gray = '0;

    // Reset held two cycles with winc asserted
    rcnt = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("reset_gray", {27'd0, wptr_gray}, 32'd0);
    check("reset_waddr", {28'd0, waddr}, 32'd0);

    // Fill 16 entries with the read pointer parked at 0
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    check("fill_gray16", {27'd0, wptr_gray}, 32'b11000);
    check("fill_full", {31'd0, wfull}, 32'd1);

    // Overflow attempts while full
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("ovf_pulse", {31'd0, woverflow}, 32'd1);
      check("ovf_hold", {27'd0, wptr_gray}, 32'b11000);
    end

    // Release: one read, full drops on the third edge
    rcnt = 1;
    step(1'b0, 1'b0);
    check("rel_e1", {31'd0, wfull}, 32'd1);
    step(1'b0, 1'b0);
    check("rel_e2", {31'd0, wfull}, 32'd1);
    step(1'b0, 1'b0);
    check("rel_e3", {31'd0, wfull}, 32'd0);
    check("rel_addr", {28'd0, waddr}, 32'd0);
    step(1'b1, 1'b0);
    check("rel_accept", {28'd0, waddr}, 32'd1);

    // Mid-operation reset with a write pending
    step(1'b1, 1'b0);
    rcnt = 0;
    step(1'b1, 1'b1);
    check("midrst_gray", {27'd0, wptr_gray}, 32'd0);

    // Wrap: 40 writes with the reader kept 4 behind
    wraps = 0;
    prev_addr = waddr;
    for (int i = 0; i < 40; i++) begin
      rcnt = (wcnt > 4) ? wcnt - 4 : 0;
      step(1'b1, 1'b0);
      check("wrap_nofull", {31'd0, wfull}, 32'd0);
      if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
      prev_addr = waddr;
    end
    check("wrap_count", 32'(wraps), 32'd2);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rcnt = 0;
        step(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        if (rcnt < wcnt && $urandom_range(0, 2) == 0) rcnt++;
        step(($urandom_range(0, 3) != 0), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
